cg_iteration_controller: RTL and testbench

- Sequencer wrapped around the conjugate-gradient ALU datapath. Starts each CG iteration by driving the ALU's reset_vXv1/reset_mXv1 phase inputs.
- Captures the new residual norm rs_new (r·r, from the vXv3 stage) and waits for mul_add3_finish, which marks the end of the p-update.
- Decides converge / continue / abort, then toggles the ping-pong bank select for the r/x/p vector memories.
- Implements the convergence test that is currently absent in the ALU.

---
 rtl/cg_iteration_controller.sv | 183 ++++++++++++++++++
 tb/tb_cg_iteration_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_iteration_controller.sv
// Iteration sequencer for the conjugate-gradient ALU: arms each iteration, captures r.r,
// applies the convergence / iteration-limit / sanity tests and flips the vector bank.
module cg_iteration_controller #(
    parameter int                         element_width = 32,
    parameter logic [element_width-1:0]   TOLERANCE     = 32'h283424DC,
    parameter int                         MAX_ITER      = 1000,
    parameter int                         ARM_CYCLES    = 2,
    parameter int                         TIMEOUT       = 65536,
    parameter int                         ITER_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [element_width-1:0] rs_new,
    input  logic                     rs_new_valid,
    input  logic                     mul_add3_finish,
    output logic                     reset_vXv1,
    output logic                     reset_mXv1,
    output logic                     bank_sel,
    output logic [ITER_W-1:0]        iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     nan_err,
    output logic                     timeout_err
);

    localparam int AC_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AC_W-1:0]   ARM_LAST = AC_W'(ARM_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_CHECK, S_DONE, S_ERROR} state_t;

    state_t                   state_q, state_d;
    logic [AC_W-1:0]          arm_cnt_q, arm_cnt_d;
    logic [WD_W-1:0]          wd_q, wd_d;
    logic [element_width-1:0] rs_q, rs_d;
    logic                     rs_seen_q, rs_seen_d;
    logic                     hold_q, hold_d;
    logic                     bank_q, bank_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     conv_q, conv_d;
    logic                     nan_q, nan_d;
    logic                     to_q, to_d;

    // Positive floats order like unsigned integers, so the magnitude bits compare directly.
    logic rs_invalid, rs_le_tol;
    assign rs_invalid = (rs_q[31] && (rs_q[30:0] != 31'd0)) || (rs_q[30:23] == 8'hFF);
    assign rs_le_tol  = (rs_q[30:0] <= TOLERANCE[30:0]);

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        wd_d      = wd_q;
        rs_d      = rs_q;
        rs_seen_d = rs_seen_q;
        hold_d    = hold_q;
        bank_d    = bank_q;
        iter_d    = iter_q;
        busy_d    = busy_q;
        done_d    = done_q;
        conv_d    = conv_q;
        nan_d     = nan_q;
        to_d      = to_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                hold_d = 1'b1;
                if (go) begin
                    state_d   = S_ARM;
                    arm_cnt_d = '0;
                    busy_d    = 1'b1;
                    iter_d    = '0;
                    bank_d    = 1'b0;
                    done_d    = 1'b0;
                    conv_d    = 1'b0;
                    nan_d     = 1'b0;
                    to_d      = 1'b0;
                end
            end
            S_ARM: begin
                if (arm_cnt_q == ARM_LAST) begin
                    state_d   = S_RUN;
                    hold_d    = 1'b0;
                    wd_d      = '0;
                    rs_d      = '0;
                    rs_seen_d = 1'b0;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                wd_d = wd_q + 1'b1;
                if (rs_new_valid && !rs_seen_q) begin
                    rs_d      = rs_new;
                    rs_seen_d = 1'b1;
                end
                // A finish on the last watchdog cycle still completes the iteration.
                if (mul_add3_finish) begin
                    state_d = S_CHECK;
                    hold_d  = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERROR;
                    hold_d  = 1'b1;
                    busy_d  = 1'b0;
                    to_d    = 1'b1;
                end
            end
            S_CHECK: begin
                iter_d = iter_q + 1'b1;
                bank_d = ~bank_q;
                if (!rs_seen_q || rs_invalid) begin
                    state_d = S_ERROR;
                    busy_d  = 1'b0;
                    nan_d   = 1'b1;
                end else if (rs_le_tol) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    conv_d  = 1'b1;
                end else if (iter_q + 1'b1 == ITER_MAX) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_ARM;
                    arm_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            arm_cnt_q <= '0;
            wd_q      <= '0;
            rs_q      <= '0;
            rs_seen_q <= 1'b0;
            hold_q    <= 1'b1;
            bank_q    <= 1'b0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            conv_q    <= 1'b0;
            nan_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            wd_q      <= wd_d;
            rs_q      <= rs_d;
            rs_seen_q <= rs_seen_d;
            hold_q    <= hold_d;
            bank_q    <= bank_d;
            iter_q    <= iter_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            conv_q    <= conv_d;
            nan_q     <= nan_d;
            to_q      <= to_d;
        end
    end

    assign reset_vXv1  = hold_q;
    assign reset_mXv1  = hold_q;
    assign bank_sel    = bank_q;
    assign iter_count  = iter_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = conv_q;
    assign nan_err     = nan_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_cg_iteration_controller.sv
// Randomised bench for cg_iteration_controller, checked against a float-level outcome model.
module tb_cg_iteration_controller;

    localparam int AC = 2;
    localparam int MI = 3;
    localparam int TO = 20;
    localparam logic [31:0] TOL_W = 32'h283424DC;
    localparam int unsigned TOL_E = 80;        // exponent field of the tolerance
    localparam int unsigned TOL_F = 'h3424DC;  // fraction field of the tolerance

    logic        clk = 1'b0;
    logic        reset, go, rs_new_valid, mul_add3_finish;
    logic [31:0] rs_new;
    logic        reset_vXv1, reset_mXv1, bank_sel, busy, done, converged, nan_err, timeout_err;
    logic [15:0] iter_count;

    int checks = 0;
    int errors = 0;
    int m_iter;
    bit m_bank;

    cg_iteration_controller #(
        .element_width(32), .TOLERANCE(TOL_W), .MAX_ITER(MI),
        .ARM_CYCLES(AC), .TIMEOUT(TO), .ITER_W(16)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .rs_new(rs_new), .rs_new_valid(rs_new_valid),
        .mul_add3_finish(mul_add3_finish), .reset_vXv1(reset_vXv1), .reset_mXv1(reset_mXv1),
        .bank_sel(bank_sel), .iter_count(iter_count), .busy(busy), .done(done),
        .converged(converged), .nan_err(nan_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 = continue, 1 = done/converged, 2 = done/iteration limit, 3 = nan_err
    function automatic int outcome(logic [31:0] v, bit seen, int iter_before);
        int unsigned ex = v[30:23];
        int unsigned fr = v[22:0];
        bit is_zero = (ex == 0) && (fr == 0);
        bit is_bad  = (ex == 255) || (v[31] && !is_zero);
        bit le_tol  = is_zero || (ex < TOL_E) || ((ex == TOL_E) && (fr <= TOL_F));
        if (!seen || is_bad) return 3;
        if (le_tol) return 1;
        if (iter_before + 1 == MI) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] pick_rs();
        case ($urandom_range(0, 11))
            0: return {1'b0, 8'($urandom_range(0, 79)), 23'($urandom)};
            1: return TOL_W;
            2: return TOL_W + 32'd1;
            3: return TOL_W - 32'd1;
            4: return 32'h7F800000 | {9'd0, 23'($urandom)};
            5: return {1'b1, 31'($urandom)};
            6: return 32'h80000000;
            default: return {1'b0, 8'($urandom_range(81, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic wait_run(input string tag);
        int n = 0;
        while (reset_vXv1 === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != AC || reset_vXv1 !== 1'b0 || reset_mXv1 !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_arm: arm_cycles=%0d reset_v=%b reset_m=%b busy=%b required %0d/0/0/1",
                     tag, n, reset_vXv1, reset_mXv1, busy, AC);
        end
    endtask

    task automatic start(input string tag);
        go = 1'b1;
        tick();
        go = 1'b0;
        m_iter = 0;
        m_bank = 1'b0;
        checks++;
        if (busy !== 1'b1 || iter_count !== 16'd0 || bank_sel !== 1'b0 || done !== 1'b0 ||
            converged !== 1'b0 || nan_err !== 1'b0 || timeout_err !== 1'b0 || reset_vXv1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: busy=%b iter=%0d bank=%b done=%b conv=%b nan=%b to=%b rv=%b required 1/0/0/0/0/0/0/1",
                     tag, busy, iter_count, bank_sel, done, converged, nan_err, timeout_err, reset_vXv1);
        end
        wait_run(tag);
    endtask

    // Called in the first RUN cycle; finishes one iteration and checks its outcome.
    task automatic run_iter(input string tag, input logic [31:0] v, input bit give, input int rs_at,
                            input int fin_at, input bit dup, input bit go_pulse, output int oc);
        for (int k = 0; k <= fin_at; k++) begin
            rs_new          = (give && k == rs_at) ? v : $urandom;
            rs_new_valid    = give && (k == rs_at || (dup && k == rs_at + 1));
            mul_add3_finish = (k == fin_at);
            go              = go_pulse && (k == 0);
            tick();
        end
        rs_new_valid = 1'b0;
        mul_add3_finish = 1'b0;
        go = 1'b0;
        oc = outcome(v, give, m_iter);
        checks++;
        if (reset_vXv1 !== 1'b1 || reset_mXv1 !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_check_state: reset_v=%b reset_m=%b busy=%b required 1/1/1",
                     tag, reset_vXv1, reset_mXv1, busy);
        end
        tick();
        m_iter++;
        m_bank = ~m_bank;
        $display("iter %s: n=%0d rs=%h seen=%0b fin_at=%0d outcome=%0d", tag, m_iter, v, give, fin_at, oc);
        checks++;
        if (iter_count !== 16'(m_iter) || bank_sel !== m_bank || busy !== (oc == 0) ||
            done !== (oc == 1 || oc == 2) || converged !== (oc == 1) || nan_err !== (oc == 3) ||
            timeout_err !== 1'b0 || reset_vXv1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_outcome: iter=%0d bank=%b busy=%b done=%b conv=%b nan=%b to=%b rv=%b required %0d/%b/%b/%b/%b/%b/0/1",
                     tag, iter_count, bank_sel, busy, done, converged, nan_err, timeout_err, reset_vXv1,
                     m_iter, m_bank, oc == 0, oc == 1 || oc == 2, oc == 1, oc == 3);
        end
        if (oc == 0) wait_run(tag);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (reset_vXv1 !== 1'b1 || reset_mXv1 !== 1'b1 || bank_sel !== 1'b0 || iter_count !== 16'd0 ||
            busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0 || nan_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: rv=%b rm=%b bank=%b iter=%0d busy=%b done=%b conv=%b nan=%b to=%b required 1/1/0/0/0/0/0/0/0",
                     tag, reset_vXv1, reset_mXv1, bank_sel, iter_count, busy, done, converged, nan_err, timeout_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go = 1'b0;
        rs_new = '0;
        rs_new_valid = 1'b0;
        mul_add3_finish = 1'b0;
        repeat (3) tick();
        check_reset_values("reset_asserted");
        reset = 1'b0;
        tick();
        check_reset_values("reset_released");
    endtask

    task automatic test_basic();
        int oc;
        repeat (4) tick();
        start("basic");
        run_iter("basic1", 32'h3F800000, 1'b1, 0, 9, 1'b0, 1'b0, oc);
        run_iter("basic2", 32'h28000000, 1'b1, 2, 6, 1'b0, 1'b0, oc);
    endtask

    task automatic test_max_iter();
        int oc;
        start("maxit");
        for (int i = 0; i < MI; i++) run_iter("maxit", 32'h3F800000, 1'b1, 1, 4, 1'b0, 1'b0, oc);
    endtask

    task automatic test_nan();
        int oc;
        start("nan");
        run_iter("nan", 32'h7FC00000, 1'b1, 0, 3, 1'b0, 1'b0, oc);
        start("nors");
        run_iter("nors", 32'h00000000, 1'b0, 0, 3, 1'b0, 1'b0, oc);
    endtask

    task automatic test_timeout();
        int n = 0;
        int oc;
        start("timeout");
        while (reset_vXv1 === 1'b0 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != TO || timeout_err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || nan_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout: run_cycles=%0d to=%b busy=%b done=%b nan=%b required %0d/1/0/0/0",
                     n, timeout_err, busy, done, nan_err, TO);
        end
        start("after_timeout");
        run_iter("fin_at_limit", 32'h00000000, 1'b1, TO - 1, TO - 1, 1'b0, 1'b0, oc);
    endtask

    task automatic test_midrun_reset();
        int oc;
        start("midrun");
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_values("midrun_reset");
        reset = 1'b0;
        tick();
        check_reset_values("midrun_after");
        start("busy_go");
        run_iter("busy_go", 32'h3F800000, 1'b1, 2, 5, 1'b0, 1'b1, oc);
        run_iter("same_cycle_tol", TOL_W, 1'b1, 5, 5, 1'b0, 1'b0, oc);
    endtask

    task automatic test_back_to_back();
        int oc;
        for (int r = 0; r < 25; r++) begin
            start("rand");
            for (int i = 0; i < MI; i++) begin
                int fin_at = $urandom_range(0, TO - 1);
                run_iter("rand", pick_rs(), ($urandom_range(0, 9) != 0), $urandom_range(0, fin_at),
                         fin_at, 1'($urandom), 1'($urandom), oc);
                if (oc != 0) break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_iter();
        test_nan();
        test_timeout();
        test_midrun_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
